scoreboard_hazard_unit: RTL and testbench
=========================================

// Module: scoreboard_hazard_unit
// PURPOSE
//  Parametrised successor to the pipeline hazard detector. It replaces the fixed EXE/MEM
//  destination compare with a per-register scoreboard of in-flight writebacks.
//  Supports configurable writeback depth, load-use stall length with forwarding enabled,
//  pipeline freeze (multi-cycle memory) and branch flush.
//  Sits at the ID stage; its hazard output stalls IF/ID and inserts a bubble into EXE.
// PARAMETERS
//  NUM_REGS   16  architectural registers tracked
//  REG_W      4   register index width, clog2(NUM_REGS)
//  WB_DEPTH   3   cycles from issue (ID->EXE) until the value is readable from the RF, >=1
//  LOAD_GAP   1   stall cycles a load consumer needs with forwarding on, < WB_DEPTH
//  PERF_W     16  stall-cycle counter width
// PORTS
//  clk           in   1         clock, rising edge
//  rst_n         in   1         asynchronous reset, active-low
//  src1          in   REG_W     ID-stage source register 1
//  src2          in   REG_W     ID-stage source register 2
//  two_src       in   1         src2 is valid for the ID instruction
//  forward_en    in   1         forwarding unit enabled
//  issue_valid   in   1         ID holds a valid instruction that wants to issue
//  issue_wb_en   in   1         that instruction writes a register
//  issue_dest    in   REG_W     its destination register
//  issue_is_load in   1         that instruction is a memory read
//  flush         in   1         branch taken in EXE; the ID instruction is squashed
//  freeze        in   1         whole pipeline held (memory not ready)
//  hazard        out  1         stall ID this cycle
//  busy_vec      out  NUM_REGS  bit r = register r has a pending write
//  stall_count   out  PERF_W    saturating count of cycles with hazard=1
// BEHAVIOUR
//  State per register r: busy[r], is_load[r], cnt[r] (width clog2(WB_DEPTH+1)).
//  Reset (rst_n=0, async): every busy/is_load/cnt = 0 and stall_count = 0.
//   Outputs reach hazard=0 and busy_vec=0 immediately. This also applies mid-operation.
//  Match: m1 = busy[src1]; m2 = two_src & busy[src2].
//  Blocking, per matched reg:
//   - forward_en=0: the reg is blocking whenever it is busy.
//   - forward_en=1: the reg is blocking only if is_load & (WB_DEPTH - cnt) < LOAD_GAP.
//  hazard = issue_valid & ~flush & (blocking(src1,m1) | blocking(src2,m2)).
//   hazard is combinational with zero latency.
//  Effective issue: fire = issue_valid & ~hazard & ~flush & ~freeze.
//  Each rising edge with freeze=1: all state held, except stall_count per the rule below.
//  Each rising edge with freeze=0:
//   - For every busy r: cnt decrements by 1. When cnt goes 1->0, busy and is_load clear.
//   - If fire & issue_wb_en: busy[issue_dest]=1, cnt=WB_DEPTH, is_load=issue_is_load.
//   - Issue overrides expiry or decrement of the same register in the same cycle.
//   - A newer write to a busy register overwrites its entry: the younger producer wins.
//  Writes with issue_wb_en=0 never touch the scoreboard.
//  Register index >= NUM_REGS is ignored: no match and no set.
//  stall_count increments on every edge where hazard=1, including freeze cycles.
//   It saturates at all-ones and never wraps.
//  Freeze and hazard together: hazard is still reported and nothing issues.
//  Flush masks hazard, so a squashed instruction is never counted as a stall.
// TESTING
//  1 Reset: drive state busy, pulse rst_n low between clock edges
//    -> busy_vec=0, hazard=0, stall_count=0 without waiting for a clock edge.
//  2 No forwarding: issue ADD r3, then SUB using src1=r3 with forward_en=0
//    -> hazard for 3 cycles (WB_DEPTH), SUB fires on cycle 4, stall_count=3.
//  3 Load-use: forward_en=1, issue LDR r5, consumer src2=r5 with two_src=1
//    -> exactly 1 stall cycle. Same stimulus with two_src=0 -> no stall.
//  4 Freeze: LDR r2 issued, freeze=1 for 4 cycles with consumer waiting
//    -> cnt[2] holds at 3, hazard stays 1, stall_count +4; on release, normal countdown.
//  5 Overwrite/expiry race: r7 at cnt=1, new write to r7 fires same edge
//    -> busy[7] stays 1 with cnt=3. Flush with issue_valid=1 -> hazard=0, no entry set.
//  6 Saturation: PERF_W=4, hold a hazard for 20 cycles -> stall_count stops at 15.

Source files
------------

// File: rtl/scoreboard_hazard_unit.sv
// ID-stage hazard detector: tracks each register's in-flight writeback and stalls
// consumers until the value can be forwarded or read from the register file.
module scoreboard_hazard_unit #(
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned REG_W    = 4,
   parameter int unsigned WB_DEPTH = 3,
   parameter int unsigned LOAD_GAP = 1,
   parameter int unsigned PERF_W   = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [REG_W-1:0]    src1,
   input  logic [REG_W-1:0]    src2,
   input  logic                two_src,
   input  logic                forward_en,
   input  logic                issue_valid,
   input  logic                issue_wb_en,
   input  logic [REG_W-1:0]    issue_dest,
   input  logic                issue_is_load,
   input  logic                flush,
   input  logic                freeze,
   output logic                hazard,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic [PERF_W-1:0]   stall_count
);

   localparam int unsigned CNT_W = $clog2(WB_DEPTH + 1);
   localparam int unsigned IDX_N = 1 << REG_W;

   logic [NUM_REGS-1:0]            busy;
   logic [NUM_REGS-1:0]            load;
   logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
   logic [PERF_W-1:0]              stall_q;

   logic [IDX_N-1:0]               busy_x;
   logic [IDX_N-1:0]               load_x;
   logic [IDX_N-1:0]               in_range;
   logic [IDX_N-1:0][CNT_W-1:0]    cnt_x;

   logic blk1;
   logic blk2;
   logic fire;
   logic set_en;

   // Widen the scoreboard to the full index space; indices past NUM_REGS read as idle
   for (genvar g = 0; g < IDX_N; g++) begin : g_idx
      if (g < NUM_REGS) begin : g_real
         assign busy_x[g]   = busy[g];
         assign load_x[g]   = load[g];
         assign cnt_x[g]    = cnt[g];
         assign in_range[g] = 1'b1;
      end else begin : g_void
         assign busy_x[g]   = 1'b0;
         assign load_x[g]   = 1'b0;
         assign cnt_x[g]    = '0;
         assign in_range[g] = 1'b0;
      end
   end

   // With forwarding, only a load still too young for the bypass network blocks
   function automatic logic blocks(input logic b, input logic ld,
                                   input logic [CNT_W-1:0] c, input logic fwd);
      logic r;
      r = 1'b0;
      if (b) begin
         if (!fwd) r = 1'b1;
         else      r = ld && ((WB_DEPTH - 32'(c)) < LOAD_GAP);
      end
      return r;
   endfunction

   always_comb begin
      blk1   = blocks(busy_x[src1], load_x[src1], cnt_x[src1], forward_en);
      blk2   = two_src & blocks(busy_x[src2], load_x[src2], cnt_x[src2], forward_en);
      hazard = issue_valid & ~flush & (blk1 | blk2);
      fire   = issue_valid & ~hazard & ~flush & ~freeze;
      set_en = fire & issue_wb_en & in_range[issue_dest];
   end

   // Per-register countdown; a new issue to a register replaces its entry outright
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
         load <= '0;
         cnt  <= '0;
      end else if (!freeze) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (set_en && (int'(issue_dest) == i)) begin
               busy[i] <= 1'b1;
               load[i] <= issue_is_load;
               cnt[i]  <= CNT_W'(WB_DEPTH);
            end else if (busy[i]) begin
               cnt[i] <= cnt[i] - CNT_W'(1);
               if (cnt[i] == CNT_W'(1)) begin
                  busy[i] <= 1'b0;
                  load[i] <= 1'b0;
               end
            end
         end
      end
   end

   // Saturating stall-cycle counter; counts during freeze as well
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (hazard && (stall_q != '1)) begin
         stall_q <= stall_q + PERF_W'(1);
      end
   end

   assign busy_vec    = busy;
   assign stall_count = stall_q;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Self-checking bench for scoreboard_hazard_unit: directed vector table plus
// hand-written async-reset and counter-saturation sequences.
module tb_scoreboard_hazard_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  src1 = '0, src2 = '0, issue_dest = '0;
   logic        two_src = 1'b0, forward_en = 1'b0, issue_valid = 1'b0;
   logic        issue_wb_en = 1'b0, issue_is_load = 1'b0, flush = 1'b0, freeze = 1'b0;
   logic        hazard, hazard4;
   logic [15:0] busy_vec, busy4;
   logic [15:0] stall_count;
   logic [3:0]  stall4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   scoreboard_hazard_unit dut (
      .clk(clk), .rst_n(rst_n), .src1(src1), .src2(src2), .two_src(two_src),
      .forward_en(forward_en), .issue_valid(issue_valid), .issue_wb_en(issue_wb_en),
      .issue_dest(issue_dest), .issue_is_load(issue_is_load), .flush(flush),
      .freeze(freeze), .hazard(hazard), .busy_vec(busy_vec), .stall_count(stall_count)
   );

   scoreboard_hazard_unit #(.PERF_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .src1(src1), .src2(src2), .two_src(two_src),
      .forward_en(forward_en), .issue_valid(issue_valid), .issue_wb_en(issue_wb_en),
      .issue_dest(issue_dest), .issue_is_load(issue_is_load), .flush(flush),
      .freeze(freeze), .hazard(hazard4), .busy_vec(busy4), .stall_count(stall4)
   );

   typedef struct {
      string       name;
      logic [3:0]  s1, s2;
      logic        two, fwd, iv, wb;
      logic [3:0]  dst;
      logic        ld, fl, fz;
      logic        exp_hz;
      logic [15:0] exp_busy;
      logic [15:0] exp_stall;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];

   task automatic check(input string name, input int idx, input logic [15:0] act,
                        input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
      end
   endtask

   task automatic add(input string n, input int s1, input int s2, input bit two,
                      input bit fwd, input bit iv, input bit wb, input int dst,
                      input bit ld, input bit fl, input bit fz, input bit hz,
                      input logic [15:0] bsy, input int st);
      vec_t v;
      v.name = n; v.s1 = 4'(s1); v.s2 = 4'(s2); v.two = two; v.fwd = fwd;
      v.iv = iv; v.wb = wb; v.dst = 4'(dst); v.ld = ld; v.fl = fl; v.fz = fz;
      v.exp_hz = hz; v.exp_busy = bsy; v.exp_stall = 16'(st);
      tbl.push_back(v);
   endtask

   task automatic idle(input logic [15:0] bsy, input int st);
      add("idle", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, bsy, st);
   endtask

   task automatic drive(input vec_t v);
      src1 = v.s1; src2 = v.s2; two_src = v.two; forward_en = v.fwd;
      issue_valid = v.iv; issue_wb_en = v.wb; issue_dest = v.dst;
      issue_is_load = v.ld; flush = v.fl; freeze = v.fz;
   endtask

   // Drive at the falling edge, compare 1ns later, well away from the rising edge
   task automatic apply(input vec_t v, input int idx);
      vec_t e;
      @(negedge clk);
      drive(v);
      exp_q.push_back(v);
      #1;
      e = exp_q.pop_front();
      check({e.name, ".hazard"}, idx, 16'(hazard), 16'(e.exp_hz));
      check({e.name, ".busy"}, idx, busy_vec, e.exp_busy);
      check({e.name, ".stall"}, idx, stall_count, e.exp_stall);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t iv_v;
      // name s1 s2 two fwd iv wb dst ld fl fz | hazard busy stall
      idle(16'h0000, 0);
      add("add_r3",      0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 16'h0000, 0);
      add("sub_r3",      3, 0, 0, 0, 1, 1, 4, 0, 0, 0, 1, 16'h0008, 0);
      add("sub_r3",      3, 0, 0, 0, 1, 1, 4, 0, 0, 0, 1, 16'h0008, 1);
      add("sub_r3",      3, 0, 0, 0, 1, 1, 4, 0, 0, 0, 1, 16'h0008, 2);
      add("sub_r3_fire", 3, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0, 16'h0000, 3);
      idle(16'h0010, 3); idle(16'h0010, 3); idle(16'h0010, 3); idle(16'h0000, 3);
      add("ldr_r5",      0, 0, 0, 1, 1, 1, 5, 1, 0, 0, 0, 16'h0000, 3);
      add("use_r5",      0, 5, 1, 1, 1, 0, 0, 0, 0, 0, 1, 16'h0020, 3);
      add("use_r5_fire", 0, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0020, 4);
      idle(16'h0020, 4);
      add("ldr_r5b",     0, 0, 0, 1, 1, 1, 5, 1, 0, 0, 0, 16'h0000, 4);
      add("use_r5_1src", 0, 5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0020, 4);
      idle(16'h0020, 4); idle(16'h0020, 4); idle(16'h0000, 4);
      add("ldr_r2",      0, 0, 0, 1, 1, 1, 2, 1, 0, 0, 0, 16'h0000, 4);
      for (int k = 0; k < 4; k++)
         add("frz_use_r2", 2, 0, 0, 1, 1, 1, 6, 0, 0, 1, 1, 16'h0004, 4 + k);
      add("use_r2",      2, 0, 0, 1, 1, 1, 6, 0, 0, 0, 1, 16'h0004, 8);
      add("use_r2_fire", 2, 0, 0, 1, 1, 1, 6, 0, 0, 0, 0, 16'h0004, 9);
      idle(16'h0044, 9); idle(16'h0040, 9); idle(16'h0040, 9); idle(16'h0000, 9);
      add("add_r7",      0, 0, 0, 1, 1, 1, 7, 0, 0, 0, 0, 16'h0000, 9);
      idle(16'h0080, 9); idle(16'h0080, 9);
      add("rewrite_r7",  0, 0, 0, 1, 1, 1, 7, 0, 0, 0, 0, 16'h0080, 9);
      idle(16'h0080, 9); idle(16'h0080, 9); idle(16'h0080, 9); idle(16'h0000, 9);
      add("add_r9",      0, 0, 0, 0, 1, 1, 9, 0, 0, 0, 0, 16'h0000, 9);
      add("flush_use_r9",9, 0, 0, 0, 1, 1, 10, 0, 1, 0, 0, 16'h0200, 9);
      idle(16'h0200, 9); idle(16'h0200, 9); idle(16'h0000, 9);
      add("ldr_r1",      0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 16'h0000, 9);
      add("add_r1",      0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 16'h0002, 9);
      add("use_r1",      1, 0, 0, 1, 1, 0, 11, 0, 0, 0, 0, 16'h0002, 9);
      idle(16'h0002, 9); idle(16'h0002, 9); idle(16'h0000, 9);
      add("frz_issue",   0, 0, 0, 1, 1, 1, 12, 0, 0, 1, 0, 16'h0000, 9);
      idle(16'h0000, 9);

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      foreach (tbl[i]) apply(tbl[i], i);

      // Mid-operation async reset between clock edges
      iv_v = tbl[1];
      @(negedge clk); drive(iv_v);
      @(negedge clk); drive(tbl[2]);
      #1;
      check("pre_rst.hazard", 0, 16'(hazard), 16'h0001);
      check("pre_rst.busy",   0, busy_vec, 16'h0008);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst.hazard", 0, 16'(hazard), 16'h0000);
      check("async_rst.busy",   0, busy_vec, 16'h0000);
      check("async_rst.stall",  0, stall_count, 16'h0000);
      check("async_rst.stall4", 0, 16'(stall4), 16'h0000);
      @(negedge clk);
      drive(tbl[0]);
      rst_n = 1'b1;

      // Hold a hazard under freeze for 20 edges; narrow counter pins at 15
      @(negedge clk); drive(iv_v);
      @(negedge clk);
      iv_v = tbl[2]; iv_v.fz = 1'b1;
      drive(iv_v);
      for (int n = 0; n < 20; n++) begin
         #1;
         check("sat.hazard", n, 16'(hazard4), 16'h0001);
         check("sat.stall4", n, 16'(stall4), 16'((n > 15) ? 15 : n));
         check("sat.stall",  n, stall_count, 16'(n));
         @(negedge clk);
      end
      #1;
      check("sat.final4",  20, 16'(stall4), 16'h000f);
      check("sat.final16", 20, stall_count, 16'd20);
      check("sat.busy",    20, busy4, 16'h0008);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
